icache_fill: RTL

//  Refill engine directly upstream of the icache data array. Accepts one line-miss request from
//  hit_read, issues a 4-beat read burst to memory, writes each 128-bit beat into the data array via the

---
 rtl/icache_fill_pkg.sv | 28 ++
 rtl/icache_fill_beat_buf.sv | 41 ++++
 rtl/icache_fill.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_pkg
// Purpose  : Shared constants, address field positions and fill FSM encoding
// Revision : 1.0  initial release
// ============================================================================
package icache_fill_pkg;

  localparam int c_addr_w   = 32;
  localparam int c_data_w   = 128;
  localparam int c_index_w  = 6;
  localparam int c_way_w    = 3;
  localparam int c_beats    = 4;

  localparam int c_off_lo   = 4;
  localparam int c_index_lo = 6;
  localparam int c_tag_lo   = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RECV = 3'd2,
    ST_TAG  = 3'd3,
    ST_DONE = 3'd4
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_fill_beat_buf.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_beat_buf
// Purpose  : One-entry valid/ready holding buffer for a read beat (offset+data)
// Revision : 1.0  initial release
// ============================================================================
module icache_fill_beat_buf #(
  parameter int WIDTH = 130
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // A full entry can be replaced in the same cycle it drains.
  assign in_ready  = !r_full | out_ready;
  assign out_valid = r_full;
  assign out_data  = r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (in_valid && in_ready) begin
      r_full <= 1'b1;
      r_data <= in_data;
    end else if (r_full && out_ready) begin
      r_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_fill.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill
// Purpose  : Icache line refill engine (4-beat burst -> data array, then tag)
//            Option macro ICACHE_FILL_CWF_EN enables critical-word-first.
// Revision : 1.0  initial release
// ============================================================================
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w,
  parameter int DATA_W  = c_data_w,
  parameter int INDEX_W = c_index_w,
  parameter int WAY_W   = c_way_w,
  parameter int BEATS   = c_beats
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic [WAY_W-1:0]         miss_way,
  input  logic                     data_array_busy,
  output logic                     mem_ar_valid,
  input  logic                     mem_ar_ready,
  output logic [ADDR_W-1:0]        mem_ar_addr,
  input  logic                     mem_r_valid,
  output logic                     mem_r_ready,
  input  logic [DATA_W-1:0]        mem_r_data,
  input  logic                     mem_r_last,
  input  logic                     mem_r_err,
  output logic                     fill2data_array_valid,
  output logic [INDEX_W-1:0]       fill2data_array_index,
  output logic [WAY_W-1:0]         fill2data_array_way,
  output logic [1:0]               fill2data_array_offset,
  output logic [DATA_W-1:0]        fill2data_array_wdata,
  output logic                     fill2tag_array_valid,
  output logic [INDEX_W-1:0]       fill2tag_array_index,
  output logic [WAY_W-1:0]         fill2tag_array_way,
  output logic [ADDR_W-c_tag_lo-1:0] fill2tag_array_tag,
`ifdef ICACHE_FILL_CWF_EN
  output logic                     cwf_valid,
  output logic [DATA_W-1:0]        cwf_data,
`endif
  output logic                     fill_done_valid,
  output logic                     fill_done_err
);

  localparam int TAG_W = ADDR_W - c_tag_lo;
  localparam int CNT_W = $clog2(BEATS + 1);

  fill_state_t        r_state;
  logic               r_miss_ready;
  logic               r_ar_valid;
  logic [ADDR_W-1:0]  r_ar_addr;
  logic [INDEX_W-1:0] r_index;
  logic [WAY_W-1:0]   r_way;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_beat_off;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_err;
  logic               r_first;
  logic               r_tag_valid;
  logic               r_done_valid;
  logic               r_done_err;

  logic               w_buf_in_ready;
  logic               w_buf_full;
  logic [DATA_W+1:0]  w_buf_out;
  logic               w_accept;
  logic               w_drain;
  logic               w_all_beats;
  logic               w_last_beat;
  logic [ADDR_W-1:0]  w_ar_addr;
  logic [1:0]         w_start_off;
  logic               w_unused_addr;

`ifdef ICACHE_FILL_CWF_EN
  assign w_ar_addr   = {miss_addr[ADDR_W-1:c_off_lo], 4'b0};
  assign w_start_off = miss_addr[c_index_lo-1:c_off_lo];
  assign cwf_valid   = w_drain & r_first;
  assign cwf_data    = w_buf_out[DATA_W-1:0];
`else
  assign w_ar_addr   = {miss_addr[ADDR_W-1:c_index_lo], 6'b0};
  assign w_start_off = 2'b00;
`endif
  assign w_unused_addr = &{1'b0, miss_addr[c_index_lo-1:0]};

  assign w_all_beats = (r_beat_cnt == CNT_W'(BEATS));
  assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign mem_r_ready = (r_state == ST_RECV) & !w_all_beats & w_buf_in_ready;
  assign w_accept    = mem_r_valid & mem_r_ready;
  // hit_read always wins the array, so the drain yields combinationally.
  assign w_drain     = w_buf_full & !data_array_busy;

  icache_fill_beat_buf #(
    .WIDTH (DATA_W + 2)
  ) u_beat_buf (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (w_accept),
    .in_ready  (w_buf_in_ready),
    .in_data   ({r_beat_off, mem_r_data}),
    .out_valid (w_buf_full),
    .out_ready (!data_array_busy),
    .out_data  (w_buf_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_miss_ready <= 1'b0;
      r_ar_valid   <= 1'b0;
      r_ar_addr    <= '0;
      r_index      <= '0;
      r_way        <= '0;
      r_tag        <= '0;
      r_beat_off   <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
      r_first      <= 1'b0;
      r_tag_valid  <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_miss_ready <= 1'b1;
          if (miss_valid && r_miss_ready) begin
            r_miss_ready <= 1'b0;
            r_ar_valid   <= 1'b1;
            r_ar_addr    <= w_ar_addr;
            r_index      <= miss_addr[c_tag_lo-1:c_index_lo];
            r_tag        <= miss_addr[ADDR_W-1:c_tag_lo];
            r_way        <= miss_way;
            r_beat_off   <= w_start_off;
            r_beat_cnt   <= '0;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ar_ready) begin
            r_ar_valid <= 1'b0;
            r_first    <= 1'b1;
            r_state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (w_accept) begin
            r_beat_off <= r_beat_off + 2'd1;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            // Beat count is authoritative; mem_r_last is only cross-checked.
            if (mem_r_err || (mem_r_last != w_last_beat)) r_err <= 1'b1;
          end
          if (w_drain) r_first <= 1'b0;
          if (w_all_beats && w_drain) begin
            r_tag_valid <= !r_err;
            r_state     <= ST_TAG;
          end
        end
        ST_TAG: begin
          r_tag_valid  <= 1'b0;
          r_done_valid <= 1'b1;
          r_done_err   <= r_err;
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          r_done_valid <= 1'b0;
          r_done_err   <= 1'b0;
          r_err        <= 1'b0;
          r_miss_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miss_ready             = r_miss_ready;
  assign mem_ar_valid           = r_ar_valid;
  assign mem_ar_addr            = r_ar_addr;
  assign fill2data_array_valid  = w_drain;
  assign fill2data_array_index  = r_index;
  assign fill2data_array_way    = r_way;
  assign fill2data_array_offset = w_buf_out[DATA_W+1:DATA_W];
  assign fill2data_array_wdata  = w_buf_out[DATA_W-1:0];
  assign fill2tag_array_valid   = r_tag_valid;
  assign fill2tag_array_index   = r_index;
  assign fill2tag_array_way     = r_way;
  assign fill2tag_array_tag     = r_tag;
  assign fill_done_valid        = r_done_valid;
  assign fill_done_err          = r_done_err;

endmodule
`default_nettype wire
